avalanche_sequencer: RTL
========================

AVALANCHE_SEQUENCER -- requirements
Module: avalanche_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum RUN cycles to wait for des_ready_i before the block aborts.
REQ-002 Parameter CLR_CYC, default 2: cycles des_reset_o is held low before each DES operation.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a sweep; ignored while busy_o=1.
REQ-006 base_i  in  64  plaintext block, sampled on an accepted start.
REQ-007 key_i  in  64  key, sampled on an accepted start.
REQ-008 des_reset_o  out  1  active-low clear to the DES core.
REQ-009 des_enable_o  out  1  DES enable.
REQ-010 des_mode_o  out  1  DES mode: 0 = encrypt during runs, 1 when idle.
REQ-011 des_data_o / des_key_o  out  64 each  operand and key to the DES core.
REQ-012 des_data_i  in  64  DES result.
REQ-013 des_ready_i  in  1  DES result valid.
REQ-014 bit_idx_o  out  6  index of the flipped plaintext bit for the current hd_o.
REQ-015 hd_o  out  7  Hamming distance between the flipped-input ciphertext and the baseline.
REQ-016 hd_valid_o  out  1  one-cycle strobe qualifying bit_idx_o and hd_o.
REQ-017 hd_sum_o  out  13; hd_min_o, hd_max_o  out  7 each: sweep statistics.
REQ-018 busy_o, done_o, error_o  out  1 each: status flags.

Function
REQ-019 States: IDLE, BASE_CLR, BASE_RUN, FLIP_CLR, FLIP_RUN, COMPARE, DONE, ERROR.
REQ-020 IDLE + start: latch base and key; clear idx, sum, max and error_o; set min to 127; go to BASE_CLR.
REQ-021 Each CLR state lasts exactly CLR_CYC cycles with des_reset_o=0, des_enable_o=0 and des_mode_o=1, then goes to the matching RUN state.
REQ-022 RUN states: des_reset_o=1, des_enable_o=1, des_mode_o=0, des_key_o=latched key.
REQ-023 des_data_o = base in BASE_RUN and base XOR (1<<idx) in FLIP_RUN.
REQ-024 des_ready_i is ignored in the first RUN cycle and sampled from the second RUN cycle onward.
REQ-025 BASE_RUN + ready: store des_data_i as the baseline, go to FLIP_CLR.
REQ-026 FLIP_RUN + ready: register des_data_i, go to COMPARE.
REQ-027 COMPARE (one cycle):
- hd = popcount(registered result XOR baseline).
- Outputs are registered on exit: hd_o, bit_idx_o=idx, hd_valid_o=1 for exactly one cycle.
- sum += hd; min and max are updated.
REQ-028 After COMPARE: if idx=63 go to DONE, else idx+1 and go to FLIP_CLR.
REQ-029 DONE: done_o=1 for one cycle, then IDLE. Statistics hold until the next accepted start.
REQ-030 Timeout: a RUN-cycle counter resets on every RUN entry. If it reaches TIMEOUT without ready, go to ERROR.
REQ-031 ERROR: error_o=1 and busy_o=0; held until the next accepted start, which clears error_o.
REQ-032 busy_o=1 in every state except IDLE and ERROR.
REQ-033 des_ready_i outside RUN states is ignored.
REQ-034 hd_sum_o maximum is 4096 (64x64); 13 bits, no overflow.

Reset
REQ-035 reset asserted, including mid-sweep, forces within the same cycle:
- state IDLE;
- des_reset_o=0, des_enable_o=0, des_mode_o=1;
- all data outputs, statistics, idx and flags to 0.
REQ-036 After reset, a new start runs a complete sweep from idx 0.

Structure
REQ-037 Package des_pkg holds the state enum, the block width constant (64), and the HD, index and sum widths.
REQ-038 One sub-module, popcount64: combinational 64-bit input, 7-bit count output.

Verification
REQ-039 Reset: all outputs at their reset values; des_mode_o=1; no hd_valid_o.
REQ-040 Real des, key 0123456789abcdef, base 3b98d2eeaeb60035:
- baseline is 6305e6ff626a4f0b;
- 64 strobes with bit_idx_o 0..63 in order;
- hd_sum_o equals the sum of the strobed hd_o values;
- done_o asserts exactly once.
REQ-041 Stub responder returning a constant result after 3 cycles: every hd_o=0, hd_sum_o=0, hd_min_o=hd_max_o=0.
REQ-042 Stub responder echoing des_data_o: every hd_o=1, hd_sum_o=64, hd_min_o=hd_max_o=1.
REQ-043 Stub that never asserts ready: error_o rises TIMEOUT cycles after BASE_RUN entry, with no hd_valid_o and no done_o.
REQ-044 reset asserted when bit_idx_o=10 is strobed:
- outputs clear at once;
- a subsequent start yields its first strobe at bit_idx_o=0;
- start pulses issued while busy have no effect.

Source files
------------

// File: rtl/des_pkg.sv
// Shared state encoding and datapath widths for the DES avalanche sequencer.
package des_pkg;

  localparam int BLOCK_W = 64;
  localparam int HD_W    = 7;
  localparam int IDX_W   = 6;
  localparam int SUM_W   = 13;

  typedef enum logic [2:0] {
    IDLE,
    BASE_CLR,
    BASE_RUN,
    FLIP_CLR,
    FLIP_RUN,
    COMPARE,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/popcount64.sv
// Combinational population count of a 64-bit word.
module popcount64
  import des_pkg::*;
(
  input  logic [BLOCK_W-1:0] value,
  output logic [HD_W-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < BLOCK_W; i++) begin
      count = count + HD_W'(value[i]);
    end
  end

endmodule

// File: rtl/avalanche_sequencer.sv
// Drives an external DES core through a baseline run plus 64 single-bit-flip runs
// and reports the ciphertext Hamming distance of each flip with sweep statistics.
module avalanche_sequencer
  import des_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CLR_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BLOCK_W-1:0] base_i,
  input  logic [BLOCK_W-1:0] key_i,
  output logic               des_reset_o,
  output logic               des_enable_o,
  output logic               des_mode_o,
  output logic [BLOCK_W-1:0] des_data_o,
  output logic [BLOCK_W-1:0] des_key_o,
  input  logic [BLOCK_W-1:0] des_data_i,
  input  logic               des_ready_i,
  output logic [IDX_W-1:0]   bit_idx_o,
  output logic [HD_W-1:0]    hd_o,
  output logic               hd_valid_o,
  output logic [SUM_W-1:0]   hd_sum_o,
  output logic [HD_W-1:0]    hd_min_o,
  output logic [HD_W-1:0]    hd_max_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o
);

  localparam logic [15:0]      CLR_LAST = 16'(CLR_CYC - 1);
  localparam logic [15:0]      RUN_LAST = 16'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_t             state, next_state;
  logic [15:0]        cyc_cnt;
  logic [BLOCK_W-1:0] base_q, key_q, baseline_q, flip_q;
  logic [IDX_W-1:0]   idx;
  logic [HD_W-1:0]    hd;
  logic               in_run, run_ready, run_expired, accept;

  popcount64 u_popcount (
    .value(flip_q ^ baseline_q),
    .count(hd)
  );

  // The first RUN cycle never completes, so a stale ready from the core is ignored.
  assign in_run      = (state == BASE_RUN) || (state == FLIP_RUN);
  assign run_ready   = in_run && (cyc_cnt != '0) && des_ready_i;
  assign run_expired = in_run && !run_ready && (cyc_cnt == RUN_LAST);
  assign accept      = start && ((state == IDLE) || (state == ERROR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    des_reset_o  = 1'b0;
    des_enable_o = 1'b0;
    des_mode_o   = 1'b1;
    des_data_o   = '0;
    des_key_o    = '0;
    case (state)
      IDLE, ERROR: if (accept) next_state = BASE_CLR;
      BASE_CLR:    if (cyc_cnt == CLR_LAST) next_state = BASE_RUN;
      FLIP_CLR:    if (cyc_cnt == CLR_LAST) next_state = FLIP_RUN;
      BASE_RUN, FLIP_RUN: begin
        des_reset_o  = 1'b1;
        des_enable_o = 1'b1;
        des_mode_o   = 1'b0;
        des_key_o    = key_q;
        des_data_o   = (state == BASE_RUN) ? base_q : (base_q ^ (BLOCK_W'(1) << idx));
        if (run_ready) begin
          next_state = (state == BASE_RUN) ? FLIP_CLR : COMPARE;
        end else if (run_expired) begin
          next_state = ERROR;
        end
      end
      COMPARE:     next_state = (idx == LAST_IDX) ? DONE : FLIP_CLR;
      DONE:        next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // Datapath: one shared cycle counter restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt    <= '0;
      base_q     <= '0;
      key_q      <= '0;
      baseline_q <= '0;
      flip_q     <= '0;
      idx        <= '0;
      bit_idx_o  <= '0;
      hd_o       <= '0;
      hd_valid_o <= 1'b0;
      hd_sum_o   <= '0;
      hd_min_o   <= '0;
      hd_max_o   <= '0;
    end else begin
      cyc_cnt    <= (next_state != state) ? '0 : cyc_cnt + 16'd1;
      hd_valid_o <= 1'b0;
      if (accept) begin
        base_q   <= base_i;
        key_q    <= key_i;
        idx      <= '0;
        hd_sum_o <= '0;
        hd_max_o <= '0;
        hd_min_o <= '1;
      end
      if ((state == BASE_RUN) && run_ready) baseline_q <= des_data_i;
      if ((state == FLIP_RUN) && run_ready) flip_q <= des_data_i;
      if (state == COMPARE) begin
        hd_o       <= hd;
        bit_idx_o  <= idx;
        hd_valid_o <= 1'b1;
        hd_sum_o   <= hd_sum_o + SUM_W'(hd);
        if (hd < hd_min_o) hd_min_o <= hd;
        if (hd > hd_max_o) hd_max_o <= hd;
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end
    end
  end

  assign busy_o  = (state != IDLE) && (state != ERROR);
  assign done_o  = (state == DONE);
  assign error_o = (state == ERROR);

endmodule
